bitop_mem_ctrl: RTL and testbench
=================================

# bitop_mem_ctrl

Parametrised single-port memory controller with word, byte-lane and bit-granular reads, writes and atomic read-modify-write bit operations. It is the next generation of the team's two-cycle word/bit/byte read memory: configurable width and depth, a valid/ready request handshake, a response pulse for every operation, and error flagging for out-of-range selectors. It sits between the datapath load/store logic and on-chip storage.

## Interface
Parameters:
- DATA_W, 32: word width; multiple of 8, at least 8.
- ADDR_W, 16: address width; depth is 2**ADDR_W words.
- SEL_W, $clog2(DATA_W): bit/byte selector width (derived; do not override).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts the request this cycle.
- req_op  in  3  operation code (see Operation).
- req_addr  in  ADDR_W  word address.
- req_sel  in  SEL_W  bit index, or byte lane in the low bits.
- req_wdata  in  DATA_W  write data; byte ops use [7:0].
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_data  out  DATA_W  response data, zero-extended.
- rsp_err  out  1  selector out of range; valid with rsp_valid.

## Operation
- Handshake: a request is accepted when req_valid && req_ready. req_ready = 1 only in IDLE with reset high. There is one outstanding operation at a time.
- Ops:
  - 0 RD_WORD: rsp_data = word.
  - 1 RD_BIT: rsp_data = {0, word[sel]}.
  - 2 RD_BYTE: rsp_data = {0, word[8*sel+:8]}.
  - 3 WR_WORD: writes req_wdata; rsp_data = req_wdata.
  - 4 WR_BYTE: writes lane sel only, other lanes unchanged; rsp_data = new word.
  - 5 BIT_SET, 6 BIT_CLR, 7 BIT_TGL: atomic RMW of bit sel; rsp_data = old word.
- Byte lane range: the lane is valid if sel < DATA_W/8. Otherwise rsp_err = 1, rsp_data = 0 and memory is unchanged. Bit ops are always in range.
- FSM states:
  - IDLE: on accept, WR_WORD writes immediately and goes to RESP. All other ops issue a read and go to RD.
  - RD: the RAM output is valid. Reads go to RESP with extraction. WR_BYTE and bit ops go to WB.
  - WB: writes the merged word, then goes to RESP.
  - RESP: pulses rsp_valid, then returns to IDLE.
- The request fields (op, addr, sel, wdata) are registered at accept; the input ports may change afterwards.
- Memory contents are not initialised and are not cleared by reset.

## Timing
- Accept at edge N. Responses:
  - WR_WORD: rsp_valid in cycle N+1.
  - Reads: rsp_valid in cycle N+2.
  - WR_BYTE and bit ops: rsp_valid in cycle N+3.
- req_ready is low from N+1 until the cycle after the response. Back-to-back throughput is one op per 2, 3 or 4 cycles.
- Reset values: req_ready 0 while reset is low, then 1 in the cycle after it rises; rsp_valid 0; rsp_data 0; rsp_err 0; FSM in IDLE.
- Reset asserted mid-operation aborts it. An RMW aborted in RD performs no write. If reset is low in the WB cycle, the write is suppressed. No response is produced for the aborted op.
- Read-after-write to the same address returns the new data; this is guaranteed by serialisation.
- rsp_data holds its value between pulses. rsp_err clears on the next response.

## Structure
- Package bitop_mem_pkg contains:
  - the op enum (RD_WORD..BIT_TGL, 3 bits);
  - the FSM state enum (IDLE, RD, WB, RESP);
  - a function computing the byte-lane count.
- Sub-module sp_ram: parameterised (DATA_W, ADDR_W) single-port RAM with one-cycle registered read and a write enable. It holds no reset logic.
- The controller contains the FSM, the request register and the extract/merge logic.

## Test plan
- Reset check: hold reset low for 3 cycles with req_valid = 1. Required: req_ready = 0, rsp_valid = 0, rsp_data = 0. After release, req_ready = 1 in the next cycle.
- WR_WORD addr 0x0010 with 0xA5A5_1234, then RD_WORD 0x0010. Required: the write response arrives at N+1; the read returns 0xA5A5_1234 at N+2.
- Byte path: RD_BYTE sel = 3 on 0xA5A5_1234 returns 0x0000_00A5. Then WR_BYTE sel = 1 with wdata 0xFF, and RD_WORD returns 0xA5A5_FF34.
- Bit ops on word 0x0000_0000 at addr 0xFFFF (top wrap):
  - BIT_SET sel = 31 returns old 0x0.
  - BIT_TGL sel = 0 returns old 0x8000_0000.
  - BIT_CLR sel = 31 returns old 0x8000_0001.
  - A final RD_WORD returns 0x0000_0001.
- Error: WR_BYTE sel = 5 with DATA_W = 32. Required: rsp_err = 1, rsp_data = 0, and the word is unchanged on re-read.
- Reset mid-RMW: assert reset in the RD cycle of a BIT_SET on a word holding 0x0. Required: no rsp_valid, and a later RD_WORD returns 0x0.

Source files
------------

// File: rtl/bitop_mem_pkg.sv
// Shared types for the bit-operation memory controller: operation codes,
// controller states and the byte-lane count helper.
package bitop_mem_pkg;

  typedef enum logic [2:0] {
    RD_WORD = 3'd0,
    RD_BIT  = 3'd1,
    RD_BYTE = 3'd2,
    WR_WORD = 3'd3,
    WR_BYTE = 3'd4,
    BIT_SET = 3'd5,
    BIT_CLR = 3'd6,
    BIT_TGL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WB   = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/bitop_mem_ctrl_sp_ram.sv
// Single-port RAM with a one-cycle registered read and a write enable.
// Contents are deliberately left uninitialised and carry no reset.
module sp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bitop_mem_ctrl.sv
// Memory controller offering word, byte-lane and bit reads/writes plus atomic
// bit set/clear/toggle, one outstanding request at a time.
module bitop_mem_ctrl
  import bitop_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int SEL_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [SEL_W-1:0]  req_sel,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int               LANES      = lane_count(DATA_W);
  localparam logic [SEL_W-1:0] LANE_LIMIT = SEL_W'(LANES);

  state_e            state, state_next;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SEL_W-1:0]  sel_q;
  logic [7:0]        byte_q;
  logic [DATA_W-1:0] merged_q, result_q;
  logic              err_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic              accept;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic [SEL_W+2:0]  lane_off;
  logic              lane_ok;
  logic              bit_hit;
  logic [DATA_W-1:0] bit_mask, byte_mask, byte_ins, rd_byte;
  logic [DATA_W-1:0] result, merged;
  logic              err;

  logic              rsp_load;
  logic [DATA_W-1:0] rsp_data_next;
  logic              rsp_err_next;

  assign req_ready = (state == IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  sp_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Lane and bit masks; shifts past the word width yield zero rather than X.
  assign lane_off  = {sel_q, 3'b000};
  assign lane_ok   = (sel_q < LANE_LIMIT);
  assign bit_mask  = DATA_W'(1) << sel_q;
  assign byte_mask = DATA_W'(8'hFF) << lane_off;
  assign byte_ins  = DATA_W'(byte_q) << lane_off;
  assign bit_hit   = |(ram_rdata & bit_mask);
  assign rd_byte   = (ram_rdata & byte_mask) >> lane_off;

  always_comb begin
    result = ram_rdata;
    merged = ram_rdata;
    err    = 1'b0;
    unique case (op_q)
      RD_WORD: result = ram_rdata;
      RD_BIT:  result = DATA_W'(bit_hit);
      RD_BYTE: begin
        if (lane_ok) begin
          result = rd_byte;
        end else begin
          result = '0;
          err    = 1'b1;
        end
      end
      WR_BYTE: begin
        if (lane_ok) begin
          merged = (ram_rdata & ~byte_mask) | byte_ins;
          result = merged;
        end else begin
          result = '0;
          err    = 1'b1;
        end
      end
      BIT_SET: merged = ram_rdata | bit_mask;
      BIT_CLR: merged = ram_rdata & ~bit_mask;
      BIT_TGL: merged = ram_rdata ^ bit_mask;
      default: result = ram_rdata;
    endcase
  end

  // Only IDLE looks at the live request; later states use the captured copy.
  always_comb begin
    state_next    = state;
    ram_we        = 1'b0;
    ram_addr      = addr_q;
    ram_wdata     = merged_q;
    rsp_load      = 1'b0;
    rsp_data_next = result_q;
    rsp_err_next  = err_q;
    unique case (state)
      IDLE: begin
        ram_addr = req_addr;
        if (accept) begin
          if (op_e'(req_op) == WR_WORD) begin
            ram_we        = 1'b1;
            ram_wdata     = req_wdata;
            rsp_load      = 1'b1;
            rsp_data_next = req_wdata;
            rsp_err_next  = 1'b0;
            state_next    = RESP;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        if (op_q == RD_WORD || op_q == RD_BIT || op_q == RD_BYTE) begin
          rsp_load      = 1'b1;
          rsp_data_next = result;
          rsp_err_next  = err;
          state_next    = RESP;
        end else begin
          state_next = WB;
        end
      end
      WB: begin
        ram_we     = reset && !err_q;
        rsp_load   = 1'b1;
        state_next = RESP;
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (rsp_load) begin
        rsp_data_q <= rsp_data_next;
        rsp_err_q  <= rsp_err_next;
      end
    end
  end

  // Request capture and RMW staging need no reset: they are always written before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_e'(req_op);
      addr_q <= req_addr;
      sel_q  <= req_sel;
      byte_q <= req_wdata[7:0];
    end
    if (state == RD) begin
      merged_q <= merged;
      result_q <= result;
      err_q    <= err;
    end
  end

endmodule

// File: tb/tb_bitop_mem_ctrl.sv
// Self-checking bench: a word-level memory model predicts every response and
// its cycle, and directed operations pin the model with literal values.
module tb_bitop_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int SEL_W  = 5;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
    int          addr;
    logic [31:0] nw;
    bit          wr;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_op = 3'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [SEL_W-1:0]  req_sel = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  int          acc_edge = 0;
  int          resp_edge = 0;
  int          rsp_count = 0;
  logic [31:0] last_data = '0;
  logic        last_err = 1'b0;
  logic [31:0] model_mem [int];
  exp_t        exp_q[$];

  bitop_mem_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .SEL_W (SEL_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_addr (req_addr),
    .req_sel  (req_sel),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Behavioural meaning of each operation on a whole word.
  function automatic void model_op(input int op, input logic [31:0] old, input int sel,
                                   input logic [31:0] wdata, output logic [31:0] data,
                                   output logic err, output logic [31:0] nw, output bit wr,
                                   output int lat);
    nw   = old;
    wr   = 1'b0;
    err  = 1'b0;
    data = old;
    lat  = 2;
    case (op)
      0: data = old;
      1: data = {31'b0, old[sel]};
      2: if (sel < 4) data = {24'b0, old[8*sel +: 8]}; else begin data = '0; err = 1'b1; end
      3: begin nw = wdata; wr = 1'b1; data = wdata; lat = 1; end
      4: begin
        lat = 3;
        if (sel < 4) begin nw[8*sel +: 8] = wdata[7:0]; wr = 1'b1; data = nw; end
        else begin data = '0; err = 1'b1; end
      end
      5: begin lat = 3; nw[sel] = 1'b1; wr = 1'b1; end
      6: begin lat = 3; nw[sel] = 1'b0; wr = 1'b1; end
      default: begin lat = 3; nw[sel] = ~old[sel]; wr = 1'b1; end
    endcase
  endfunction

  // A reset sampled at an edge aborts whatever the model still had pending.
  always @(posedge clk) begin
    edge_cnt++;
    if (!reset) begin
      exp_q.delete();
      last_data = '0;
      last_err  = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    bit   exp_valid;
    exp_t h;
    if (edge_cnt > 0) begin
      exp_valid = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
      if (rsp_valid) rsp_count++;
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      checkOutput("req_ready", 32'(req_ready), 32'(reset && exp_q.size() == 0));
      if (exp_valid) begin
        h = exp_q.pop_front();
        checkOutput("rsp_data", rsp_data, h.data);
        checkOutput("rsp_err", 32'(rsp_err), 32'(h.err));
        if (h.wr) model_mem[h.addr] = h.nw;
        last_data = h.data;
        last_err  = h.err;
        resp_edge = edge_cnt;
      end else begin
        checkOutput("rsp_data_hold", rsp_data, last_data);
        checkOutput("rsp_err_hold", 32'(rsp_err), 32'(last_err));
      end
    end
  end

  task automatic applyStimulus(input int op, input int addr, input int sel, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] old, d, nw;
    logic        er;
    bit          wr, ok;
    int          lat;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_op    = 3'(op);
    req_addr  = 16'(addr);
    req_sel   = 5'(sel);
    req_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      if (ok) break;
    end
    #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom());
    req_addr  = 16'($urandom());
    req_sel   = 5'($urandom());
    req_wdata = $urandom();
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=%0d expected=%0d", 0, 1);
      return;
    end
    acc_edge = edge_cnt;
    old = model_mem.exists(addr) ? model_mem[addr] : 32'h0;
    model_op(op, old, sel, wdata, d, er, nw, wr, lat);
    e.due  = acc_edge + lat - 1;
    e.data = d;
    e.err  = er;
    e.addr = addr;
    e.nw   = nw;
    e.wr   = wr;
    exp_q.push_back(e);
  endtask

  task automatic waitResponse();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_timeout actual=%0d expected=%0d", exp_q.size(), 0);
      exp_q.delete();
    end
    #1;
  endtask

  task automatic doOp(input string name, input int op, input int addr, input int sel,
                      input logic [31:0] wdata, input logic [31:0] exp_data,
                      input logic exp_err, input int exp_lat);
    applyStimulus(op, addr, sel, wdata);
    waitResponse();
    checkOutput({name, "_data"}, last_data, exp_data);
    checkOutput({name, "_err"}, 32'(last_err), 32'(exp_err));
    checkOutput({name, "_lat"}, 32'(resp_edge - acc_edge + 1), 32'(exp_lat));
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog actual=%0d expected=%0d", edge_cnt, 0);
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin : main
    int cnt0;
    reset     = 1'b0;
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_addr  = 16'h0010;
    req_wdata = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_data", rsp_data, 32'd0);
    end
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    doOp("wr_word", 3, 16'h0010, 0, 32'hA5A5_1234, 32'hA5A5_1234, 1'b0, 1);
    doOp("rd_word", 0, 16'h0010, 0, 32'h0, 32'hA5A5_1234, 1'b0, 2);
    doOp("rd_byte3", 2, 16'h0010, 3, 32'h0, 32'h0000_00A5, 1'b0, 2);
    doOp("rd_byte0", 2, 16'h0010, 0, 32'h0, 32'h0000_0034, 1'b0, 2);
    doOp("wr_byte1", 4, 16'h0010, 1, 32'h1234_56FF, 32'hA5A5_FF34, 1'b0, 3);
    doOp("rd_after_wb", 0, 16'h0010, 0, 32'h0, 32'hA5A5_FF34, 1'b0, 2);

    doOp("clr_top", 3, 16'hFFFF, 0, 32'h0, 32'h0, 1'b0, 1);
    doOp("bit_set31", 5, 16'hFFFF, 31, 32'h0, 32'h0, 1'b0, 3);
    doOp("bit_tgl0", 7, 16'hFFFF, 0, 32'h0, 32'h8000_0000, 1'b0, 3);
    doOp("bit_clr31", 6, 16'hFFFF, 31, 32'h0, 32'h8000_0001, 1'b0, 3);
    doOp("rd_top", 0, 16'hFFFF, 0, 32'h0, 32'h0000_0001, 1'b0, 2);
    doOp("rd_bit0", 1, 16'hFFFF, 0, 32'h0, 32'h0000_0001, 1'b0, 2);
    doOp("rd_bit31", 1, 16'hFFFF, 31, 32'h0, 32'h0000_0000, 1'b0, 2);

    doOp("wr_byte_bad", 4, 16'h0010, 5, 32'h0000_0077, 32'h0, 1'b1, 3);
    doOp("rd_after_bad", 0, 16'h0010, 0, 32'h0, 32'hA5A5_FF34, 1'b0, 2);
    doOp("rd_byte_bad", 2, 16'h0010, 4, 32'h0, 32'h0, 1'b1, 2);

    doOp("clr_abort", 3, 16'h0020, 0, 32'h0, 32'h0, 1'b0, 1);
    cnt0 = rsp_count;
    applyStimulus(5, 16'h0020, 4, 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_rd_no_rsp", 32'(rsp_count - cnt0), 32'd0);
    doOp("rd_after_abort_rd", 0, 16'h0020, 0, 32'h0, 32'h0, 1'b0, 2);

    cnt0 = rsp_count;
    applyStimulus(7, 16'h0020, 7, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_wb_no_rsp", 32'(rsp_count - cnt0), 32'd0);
    doOp("rd_after_abort_wb", 0, 16'h0020, 0, 32'h0, 32'h0, 1'b0, 2);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
